l2t_sii_iq: RTL and testbench
=============================

# l2t_sii_iq

L2-tag-side receiver for the SII→L2T inbound request channel, one instance per L2 tag bank. It deframes the `sii_l2t_req_vld` / `sii_l2t_req[31:0]` word stream into headers and payload, and queues complete requests for the L2 pipe. It returns `l2t_sii_iq_dequeue` when the pipe accepts an entry, and `l2t_sii_wib_dequeue` when a WRI entry's 64 B of write data has drained.

## Interface
- `DEPTH`, 4: request entries, power of 2, ≥2.
- `iol2clk`  in  1  clock; all logic on its rising edge.
- `cluster_arst_l`  in  1  reset, asynchronous, active-low.
- `sii_l2t_req_vld`  in  1  start of request; one-cycle pulse.
- `sii_l2t_req`  in  32  header and payload words.
- `iq_hdr_vld`  out  1  head entry complete and valid.
- `iq_hdr`  out  64  head header: {word0, word1}.
- `iq_wr8_data`  out  64  WR8 payload {data0, data1}; zero for other commands.
- `iq_pop`  in  1  pipe accepts the head entry; ignored unless `iq_hdr_vld`.
- `wib_data_vld`  out  1  WRI write-data word valid.
- `wib_data`  out  32  WRI write-data word.
- `l2t_sii_iq_dequeue`  out  1  one-cycle pulse per accepted pop.
- `l2t_sii_wib_dequeue`  out  1  one-cycle pulse with the last WRI data word.
- `iq_err`  out  1  sticky error; present only with the macro.
- `iq_err_cnt`  out  8  error count; present only with the macro.

## Operation
- **Framing.**
  - Cycle T: `req_vld` is high.
  - T+1: word0 (header high). T+2: word1 (header low).
  - From T+3: payload words, back-to-back.
  - Command = word0[31:29]: 3'b001 RD (0 payload words), 3'b010 WR8 (2 words), 3'b100 WRI (16 words).
  - Any other command is treated as RD.
- **Capture FSM.** States IDLE, HDR0, HDR1, DATA.
  - IDLE→HDR0 on `req_vld`.
  - HDR0→HDR1 unconditionally.
  - HDR1→IDLE if payload count is 0, else HDR1→DATA.
  - DATA: 4-bit word counter; leaves DATA for IDLE when the counter reaches payload−1.
  - The entry is written at the write pointer and committed (valid set) on the cycle the last word is captured.
- **`req_vld` outside IDLE** is a protocol error. It is ignored; framing continues.
- **Full queue.** If `req_vld` arrives while all DEPTH entries are valid, this is an overflow error. The whole request, including its later words, is consumed and discarded, and the FSM still walks the states. SII is credit-limited, so this case does not occur legitimately.
- **Pop.** `iq_pop && iq_hdr_vld`:
  - frees the head entry;
  - advances the read pointer;
  - pulses `l2t_sii_iq_dequeue` the next cycle.
- **WRI drain.**
  - Popping a WRI entry starts a stream of 16 consecutive `wib_data_vld` cycles, words 0..15 in arrival order.
  - The entry is freed on the pop; its data is copied to a 16×32 drain buffer.
  - `l2t_sii_wib_dequeue` is asserted in the same cycle as word 15.
  - While streaming, `iq_hdr_vld` is forced low, so no further pop can occur.
- **Pointers** are log2(DEPTH)+1 bits: full when the MSBs differ and the rest are equal; empty when all bits are equal. Wrap is natural modulo 2·DEPTH.
- **Simultaneous commit and pop** in one cycle are both honoured; the count is unchanged.

## Timing
- **Reset values:** every output is 0; FSM in IDLE; pointers 0; all entries invalid. Reset during capture or drain discards everything, with no dequeue pulse.
- **Header availability:** RD with `req_vld` at T gives `iq_hdr_vld` at T+3 (registered), if the queue was empty. WR8 at T+5; WRI at T+19.
- **Pop to dequeue:** `iq_pop` at cycle P gives `l2t_sii_iq_dequeue` at P+1. For WRI, `wib_data` words 0..15 appear at P+1..P+16, and `l2t_sii_wib_dequeue` at P+16.
- **Next header:** `iq_hdr_vld` for the next entry earliest P+1 (non-WRI pop) or P+17 (WRI pop).
- Back-to-back SII requests with no idle gap are accepted: `req_vld` may assert in the cycle after the previous request's last word.

## Configuration
- **`L2T_SII_IQ_ERR_EN` defined:**
  - overflow and protocol errors set `iq_err` (sticky until reset);
  - each error increments `iq_err_cnt`, saturating at 255;
  - both errors in one cycle count as 1.
- **`L2T_SII_IQ_ERR_EN` undefined:** the ports and logic are absent; errors are silently dropped as above.

## Structure
- **Package `l2t_sii_pkg`:**
  - command encodings `CMD_RD`, `CMD_WR8`, `CMD_WRI`;
  - payload-length function (cmd→0/2/16);
  - FSM state enum;
  - `WRI_WORDS = 16`.
- **Sub-module `l2t_sii_wib_drain`:** 16×32 buffer, 4-bit counter, `wib_data_vld`, `l2t_sii_wib_dequeue`, busy flag back to the top.

## Test plan
- **Single RD:** `req_vld` at T, header 0x2000_0040 / 0x0000_1000. Expect `iq_hdr_vld` at T+3 with `iq_hdr`=0x2000_0040_0000_1000. Pop at T+4; expect `l2t_sii_iq_dequeue` at T+5 only.
- **WR8:** header word0=0x4000_0000, data 0xAAAA_5555 then 0x1234_5678. Expect `iq_wr8_data`=0xAAAA_5555_1234_5678 at T+5; no `wib_data_vld` or `l2t_sii_wib_dequeue` after the pop.
- **WRI:** 16 words 0..15 (value = index). Pop at P; expect `wib_data`=0..15 at P+1..P+16, `l2t_sii_wib_dequeue` at P+16 only, `iq_hdr_vld` low throughout.
- **Fill and wrap:** 4 back-to-back RDs with DEPTH=4 and no pops, then a 5th. Expect the 5th dropped and, with the macro, `iq_err`=1, `iq_err_cnt`=1. Then pop 4 and enqueue 4 more; expect FIFO order preserved across the wrap.
- **Simultaneous commit and pop:** an RD commits while the head is popped. Expect the occupancy count unchanged and both headers delivered in order.
- **Reset mid-WRI capture** (after word 7): expect all outputs 0, queue empty, and no dequeue pulse after reset.

Source files
------------

// File: rtl/l2t_sii_pkg.sv
// Shared definitions for the SII->L2T inbound request queue.
// Holds the command encodings, payload sizing and the capture FSM states.
package l2t_sii_pkg;

    localparam logic [2:0] CMD_RD  = 3'b001;
    localparam logic [2:0] CMD_WR8 = 3'b010;
    localparam logic [2:0] CMD_WRI = 3'b100;

    localparam int WRI_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA
    } cap_state_t;

    // Unknown commands carry no payload and behave like RD.
    function automatic logic [4:0] payload_len(input logic [2:0] cmd);
        case (cmd)
            CMD_WR8: return 5'd2;
            CMD_WRI: return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/l2t_sii_wib_drain.sv
// WRI write-data drain: holds a popped entry's 16 words and streams them out,
// one per cycle, flagging the last word with the WIB dequeue pulse.
module l2t_sii_wib_drain
    import l2t_sii_pkg::*;
(
    input  logic                       iol2clk,
    input  logic                       cluster_arst_l,
    input  logic                       start,
    input  logic [WRI_WORDS-1:0][31:0] load_data,
    output logic                       wib_data_vld,
    output logic [31:0]                wib_data,
    output logic                       l2t_sii_wib_dequeue,
    output logic                       busy
);

    logic [WRI_WORDS-1:0][31:0] drain_buf;
    logic [3:0]                 cnt_q;
    logic                       busy_q;

    always_ff @(posedge iol2clk or negedge cluster_arst_l) begin
        if (!cluster_arst_l) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= 4'd0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(WRI_WORDS - 1))
                busy_q <= 1'b0;
        end
    end

    // Data storage needs no reset; it is only observed while busy.
    always_ff @(posedge iol2clk) begin
        if (start)
            drain_buf <= load_data;
    end

    assign busy                = busy_q;
    assign wib_data_vld        = busy_q;
    assign wib_data            = busy_q ? drain_buf[cnt_q] : 32'd0;
    assign l2t_sii_wib_dequeue = busy_q && (cnt_q == 4'(WRI_WORDS - 1));

endmodule

// File: rtl/l2t_sii_iq.sv
// L2T-side SII inbound request queue: deframes header/payload words and queues
// complete requests. Optional error reporting via `L2T_SII_IQ_ERR_EN.
module l2t_sii_iq
    import l2t_sii_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        iol2clk,
    input  logic        cluster_arst_l,
    input  logic        sii_l2t_req_vld,
    input  logic [31:0] sii_l2t_req,
    output logic        iq_hdr_vld,
    output logic [63:0] iq_hdr,
    output logic [63:0] iq_wr8_data,
    input  logic        iq_pop,
    output logic        wib_data_vld,
    output logic [31:0] wib_data,
    output logic        l2t_sii_iq_dequeue,
    output logic        l2t_sii_wib_dequeue
`ifdef L2T_SII_IQ_ERR_EN
    ,
    output logic        iq_err,
    output logic [7:0]  iq_err_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    cap_state_t state_q, state_d;
    logic [2:0]       cmd_q;
    logic [4:0]       plen_q;
    logic [3:0]       word_cnt_q;
    logic             drop_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             dequeue_q;

    logic [63:0]                hdr_mem [DEPTH];
    logic [63:0]                wr8_mem [DEPTH];
    logic [WRI_WORDS-1:0][31:0] wri_mem [DEPTH];

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic full, empty, last_word, commit, head_vld, pop_ok, drain_start, drain_busy;
    logic [63:0] head_hdr;

    assign wr_idx    = wr_ptr_q[IDX_W-1:0];
    assign rd_idx    = rd_ptr_q[IDX_W-1:0];
    assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign last_word = (state_q == ST_DATA) && ({1'b0, word_cnt_q} == plen_q - 5'd1);
    assign commit    = !drop_q && (((state_q == ST_HDR1) && (plen_q == 5'd0)) || last_word);

    always_ff @(posedge iol2clk or negedge cluster_arst_l) begin
        if (!cluster_arst_l)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // req_vld is only honoured in IDLE; elsewhere the frame simply runs its course.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sii_l2t_req_vld) state_d = ST_HDR0;
            ST_HDR0: state_d = ST_HDR1;
            ST_HDR1: state_d = (plen_q == 5'd0) ? ST_IDLE : ST_DATA;
            ST_DATA: if (last_word) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iol2clk or negedge cluster_arst_l) begin
        if (!cluster_arst_l) begin
            cmd_q      <= 3'd0;
            plen_q     <= 5'd0;
            word_cnt_q <= 4'd0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dequeue_q  <= 1'b0;
        end else begin
            dequeue_q <= pop_ok;
            if (state_q == ST_IDLE && sii_l2t_req_vld)
                drop_q <= full;
            if (state_q == ST_HDR0) begin
                cmd_q  <= sii_l2t_req[31:29];
                plen_q <= payload_len(sii_l2t_req[31:29]);
            end
            word_cnt_q <= (state_q == ST_DATA) ? word_cnt_q + 4'd1 : 4'd0;
            if (commit)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Words land straight in the slot at the write pointer; a dropped request
    // must not touch it because that slot is the still-valid head.
    always_ff @(posedge iol2clk) begin
        if (!drop_q) begin
            if (state_q == ST_HDR0)
                hdr_mem[wr_idx][63:32] <= sii_l2t_req;
            if (state_q == ST_HDR1)
                hdr_mem[wr_idx][31:0] <= sii_l2t_req;
            if (state_q == ST_DATA && cmd_q == CMD_WR8) begin
                if (!word_cnt_q[0])
                    wr8_mem[wr_idx][63:32] <= sii_l2t_req;
                else
                    wr8_mem[wr_idx][31:0] <= sii_l2t_req;
            end
            if (state_q == ST_DATA && cmd_q == CMD_WRI)
                wri_mem[wr_idx][word_cnt_q] <= sii_l2t_req;
        end
    end

    assign head_vld    = !empty && !drain_busy;
    assign head_hdr    = hdr_mem[rd_idx];
    assign pop_ok      = iq_pop && head_vld;
    assign drain_start = pop_ok && (head_hdr[63:61] == CMD_WRI);

    assign iq_hdr_vld         = head_vld;
    assign iq_hdr             = head_vld ? head_hdr : 64'd0;
    assign iq_wr8_data        = (head_vld && head_hdr[63:61] == CMD_WR8) ? wr8_mem[rd_idx] : 64'd0;
    assign l2t_sii_iq_dequeue = dequeue_q;

    l2t_sii_wib_drain u_drain (
        .iol2clk             (iol2clk),
        .cluster_arst_l      (cluster_arst_l),
        .start               (drain_start),
        .load_data           (wri_mem[rd_idx]),
        .wib_data_vld        (wib_data_vld),
        .wib_data            (wib_data),
        .l2t_sii_wib_dequeue (l2t_sii_wib_dequeue),
        .busy                (drain_busy)
    );

`ifdef L2T_SII_IQ_ERR_EN
    logic       proto_err, ovf_err, err_q;
    logic [7:0] err_cnt_q;

    assign proto_err = sii_l2t_req_vld && (state_q != ST_IDLE);
    assign ovf_err   = sii_l2t_req_vld && (state_q == ST_IDLE) && full;

    always_ff @(posedge iol2clk or negedge cluster_arst_l) begin
        if (!cluster_arst_l) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else if (proto_err || ovf_err) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign iq_err     = err_q;
    assign iq_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_l2t_sii_iq.sv
// Directed self-checking bench for l2t_sii_iq (DEPTH=4).
// Error-port checks are compiled in when L2T_SII_IQ_ERR_EN is defined.
module tb_l2t_sii_iq;

    logic        iol2clk = 1'b0;
    logic        cluster_arst_l = 1'b0;
    logic        sii_l2t_req_vld = 1'b0;
    logic [31:0] sii_l2t_req = 32'd0;
    logic        iq_pop = 1'b0;
    logic        iq_hdr_vld;
    logic [63:0] iq_hdr;
    logic [63:0] iq_wr8_data;
    logic        wib_data_vld;
    logic [31:0] wib_data;
    logic        l2t_sii_iq_dequeue;
    logic        l2t_sii_wib_dequeue;
`ifdef L2T_SII_IQ_ERR_EN
    logic        iq_err;
    logic [7:0]  iq_err_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    logic [31:0] payload [16];

    l2t_sii_iq #(.DEPTH(4)) dut (
        .iol2clk             (iol2clk),
        .cluster_arst_l      (cluster_arst_l),
        .sii_l2t_req_vld     (sii_l2t_req_vld),
        .sii_l2t_req         (sii_l2t_req),
        .iq_hdr_vld          (iq_hdr_vld),
        .iq_hdr              (iq_hdr),
        .iq_wr8_data         (iq_wr8_data),
        .iq_pop              (iq_pop),
        .wib_data_vld        (wib_data_vld),
        .wib_data            (wib_data),
        .l2t_sii_iq_dequeue  (l2t_sii_iq_dequeue),
        .l2t_sii_wib_dequeue (l2t_sii_wib_dequeue)
`ifdef L2T_SII_IQ_ERR_EN
        ,
        .iq_err              (iq_err),
        .iq_err_cnt          (iq_err_cnt)
`endif
    );

    always #5 iol2clk = ~iol2clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic stepCycle;
        @(posedge iol2clk);
        #1;
    endtask

    // Drives one full frame starting in the current cycle; returns in the cycle after the last word.
    task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1, input int n);
        sii_l2t_req_vld = 1'b1;
        stepCycle();
        sii_l2t_req_vld = 1'b0;
        sii_l2t_req = w0;
        stepCycle();
        sii_l2t_req = w1;
        stepCycle();
        for (int i = 0; i < n; i++) begin
            sii_l2t_req = payload[i];
            stepCycle();
        end
        sii_l2t_req = 32'd0;
    endtask

    task automatic popOne;
        iq_pop = 1'b1;
        stepCycle();
        iq_pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;

        repeat (3) stepCycle();
        cluster_arst_l = 1'b1;
        stepCycle();
        checkOutput("rst hdr_vld", 64'(iq_hdr_vld), 64'd0);
        checkOutput("rst hdr", iq_hdr, 64'd0);
        checkOutput("rst wr8", iq_wr8_data, 64'd0);
        checkOutput("rst wib_vld", 64'(wib_data_vld), 64'd0);
        checkOutput("rst deq", 64'(l2t_sii_iq_dequeue), 64'd0);
        checkOutput("rst wib_deq", 64'(l2t_sii_wib_dequeue), 64'd0);
`ifdef L2T_SII_IQ_ERR_EN
        checkOutput("rst err", 64'(iq_err), 64'd0);
        checkOutput("rst err_cnt", 64'(iq_err_cnt), 64'd0);
`endif

        // Single RD: header visible at T+3, dequeue only at T+5
        applyStimulus(32'h2000_0040, 32'h0000_1000, 0);
        checkOutput("rd hdr_vld", 64'(iq_hdr_vld), 64'd1);
        checkOutput("rd hdr", iq_hdr, 64'h2000_0040_0000_1000);
        checkOutput("rd wr8 zero", iq_wr8_data, 64'd0);
        stepCycle();
        iq_pop = 1'b1;
        checkOutput("rd deq early", 64'(l2t_sii_iq_dequeue), 64'd0);
        stepCycle();
        iq_pop = 1'b0;
        checkOutput("rd deq", 64'(l2t_sii_iq_dequeue), 64'd1);
        checkOutput("rd empty", 64'(iq_hdr_vld), 64'd0);
        stepCycle();
        checkOutput("rd deq once", 64'(l2t_sii_iq_dequeue), 64'd0);

        // WR8 payload and no WIB activity on its pop
        payload[0] = 32'hAAAA_5555;
        payload[1] = 32'h1234_5678;
        applyStimulus(32'h4000_0000, 32'h0000_0800, 2);
        checkOutput("wr8 hdr_vld", 64'(iq_hdr_vld), 64'd1);
        checkOutput("wr8 hdr", iq_hdr, 64'h4000_0000_0000_0800);
        checkOutput("wr8 data", iq_wr8_data, 64'hAAAA_5555_1234_5678);
        popOne();
        checkOutput("wr8 deq", 64'(l2t_sii_iq_dequeue), 64'd1);
        seen = 0;
        for (int i = 0; i < 18; i++) begin
            if (wib_data_vld || l2t_sii_wib_dequeue) seen++;
            stepCycle();
        end
        checkOutput("wr8 no drain", 64'(seen), 64'd0);

        // WRI followed by an RD; the RD must stay hidden until the drain ends
        for (int i = 0; i < 16; i++) payload[i] = 32'(i);
        applyStimulus(32'h8000_0000, 32'h0000_2000, 16);
        checkOutput("wri hdr_vld", 64'(iq_hdr_vld), 64'd1);
        checkOutput("wri hdr", iq_hdr, 64'h8000_0000_0000_2000);
        applyStimulus(32'h2000_0001, 32'h0000_3000, 0);
        iq_pop = 1'b1;
        checkOutput("wri vld before pop", 64'(wib_data_vld), 64'd0);
        stepCycle();
        iq_pop = 1'b0;
        checkOutput("wri deq", 64'(l2t_sii_iq_dequeue), 64'd1);
        for (int k = 0; k < 16; k++) begin
            checkOutput("wri vld", 64'(wib_data_vld), 64'd1);
            checkOutput("wri data", 64'(wib_data), 64'(k));
            checkOutput("wri wib_deq", 64'(l2t_sii_wib_dequeue), 64'(k == 15));
            checkOutput("wri hdr hidden", 64'(iq_hdr_vld), 64'd0);
            stepCycle();
        end
        checkOutput("wri vld end", 64'(wib_data_vld), 64'd0);
        checkOutput("wri wib_deq end", 64'(l2t_sii_wib_dequeue), 64'd0);
        checkOutput("post wri hdr_vld", 64'(iq_hdr_vld), 64'd1);
        checkOutput("post wri hdr", iq_hdr, 64'h2000_0001_0000_3000);
        popOne();
        checkOutput("post wri empty", 64'(iq_hdr_vld), 64'd0);

        // Fill to DEPTH, overflow with a fifth, then drain and refill across the wrap
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h2000_0100 + 32'(i), 32'h0000_0010 + 32'(i), 0);
        applyStimulus(32'h2000_0BAD, 32'h0000_0BAD, 0);
`ifdef L2T_SII_IQ_ERR_EN
        checkOutput("ovf err", 64'(iq_err), 64'd1);
        checkOutput("ovf err_cnt", 64'(iq_err_cnt), 64'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill hdr_vld", 64'(iq_hdr_vld), 64'd1);
            checkOutput("fill hdr", iq_hdr, {32'h2000_0100 + 32'(i), 32'h0000_0010 + 32'(i)});
            popOne();
        end
        checkOutput("fill drained", 64'(iq_hdr_vld), 64'd0);
        for (int i = 0; i < 4; i++)
            applyStimulus(32'h2000_0200 + 32'(i), 32'h0000_0020 + 32'(i), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wrap hdr", iq_hdr, {32'h2000_0200 + 32'(i), 32'h0000_0020 + 32'(i)});
            popOne();
        end
        checkOutput("wrap drained", 64'(iq_hdr_vld), 64'd0);

        // Commit of B in the same cycle as the pop of A
        applyStimulus(32'h2000_00A0, 32'h0000_00A1, 0);
        sii_l2t_req_vld = 1'b1;
        stepCycle();
        sii_l2t_req_vld = 1'b0;
        sii_l2t_req = 32'h2000_00B0;
        stepCycle();
        sii_l2t_req = 32'h0000_00B1;
        iq_pop = 1'b1;
        checkOutput("simul head A", iq_hdr, 64'h2000_00A0_0000_00A1);
        stepCycle();
        iq_pop = 1'b0;
        sii_l2t_req = 32'd0;
        checkOutput("simul deq", 64'(l2t_sii_iq_dequeue), 64'd1);
        checkOutput("simul hdr_vld", 64'(iq_hdr_vld), 64'd1);
        checkOutput("simul head B", iq_hdr, 64'h2000_00B0_0000_00B1);
        popOne();
        checkOutput("simul one left", 64'(iq_hdr_vld), 64'd0);

        // Reset in the middle of a WRI capture with an RD waiting in the queue
        applyStimulus(32'h2000_0077, 32'h0000_0077, 0);
        sii_l2t_req_vld = 1'b1;
        stepCycle();
        sii_l2t_req_vld = 1'b0;
        sii_l2t_req = 32'h8000_0000;
        stepCycle();
        sii_l2t_req = 32'h0000_4000;
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            sii_l2t_req = payload[i];
            stepCycle();
        end
        sii_l2t_req = 32'd0;
        cluster_arst_l = 1'b0;
        #1;
        checkOutput("mid rst hdr_vld", 64'(iq_hdr_vld), 64'd0);
        checkOutput("mid rst hdr", iq_hdr, 64'd0);
        checkOutput("mid rst deq", 64'(l2t_sii_iq_dequeue), 64'd0);
`ifdef L2T_SII_IQ_ERR_EN
        checkOutput("mid rst err", 64'(iq_err), 64'd0);
`endif
        stepCycle();
        cluster_arst_l = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (iq_hdr_vld || l2t_sii_iq_dequeue || wib_data_vld || l2t_sii_wib_dequeue) seen++;
        end
        checkOutput("post rst quiet", 64'(seen), 64'd0);
        applyStimulus(32'h2000_0055, 32'h0000_0055, 0);
        checkOutput("post rst rd", iq_hdr, 64'h2000_0055_0000_0055);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
